alu_seq_unit: RTL and testbench



---
 rtl/alu_seq_pkg.sv | 27 ++
 rtl/alu_seq_unit_if.sv | 23 ++
 rtl/alu_muldiv_iter.sv | 111 +++++++++++
 rtl/alu_seq_unit.sv | 131 +++++++++++++
 tb/tb_alu_seq_unit.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, FSM state encoding and width defaults.
package alu_seq_pkg;

  localparam int unsigned WidthDef   = 32;
  localparam int unsigned MdItersDef = 32;

  localparam logic [5:0] OpAdd  = 6'h03;
  localparam logic [5:0] OpSub  = 6'h04;
  localparam logic [5:0] OpAnd  = 6'h05;
  localparam logic [5:0] OpOr   = 6'h06;
  localparam logic [5:0] OpMul  = 6'h0F;
  localparam logic [5:0] OpDiv  = 6'h10;
  localparam logic [5:0] OpNeg  = 6'h11;
  localparam logic [5:0] OpNot  = 6'h12;
  localparam logic [5:0] OpShr  = 6'h19;
  localparam logic [5:0] OpShra = 6'h1A;
  localparam logic [5:0] OpShl  = 6'h1B;
  localparam logic [5:0] OpRor  = 6'h1C;
  localparam logic [5:0] OpRol  = 6'h1D;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StDone
  } state_e;

endpackage

// File: rtl/alu_seq_unit_if.sv
// opSelect/start/finished handshake plus operand and result buses of the sequential ALU.
interface alu_seq_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic [5:0]       opSelect;
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic             finished;
  logic             busy;

  modport master (
    output opSelect, start, A, B,
    input  result_lo, result_hi, finished, busy
  );

  modport slave (
    input  opSelect, start, A, B,
    output result_lo, result_hi, finished, busy
  );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Shared Booth-multiply / restoring-divide datapath, one step per cycle after load.
// Divider hardware exists only when ALU_SEQ_DIV_EN is defined.
module alu_muldiv_iter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MD_ITERS = 32
) (
  input  logic             Clock,
  input  logic             clear,
  input  logic             load,
`ifdef ALU_SEQ_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             last,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);
  localparam int unsigned CntW = (MD_ITERS > 1) ? $clog2(MD_ITERS) : 1;

  // acc is one bit wider so Booth add/sub of the most negative multiplicand cannot overflow
  logic [WIDTH:0]   acc_q, acc_d, m_q, sum;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CntW-1:0]  cnt_q;
  logic             run_q;
`ifdef ALU_SEQ_DIV_EN
  logic             div_q, neg_quo_q, neg_rem_q;
  logic [WIDTH:0]   shifted, trial;
  logic [WIDTH-1:0] a_mag, b_mag;
`endif

  assign last = run_q && (cnt_q == CntW'(MD_ITERS - 1));

  always_comb begin
    unique case ({q_q[0], q1_q})
      2'b01:   sum = acc_q + m_q;
      2'b10:   sum = acc_q - m_q;
      default: sum = acc_q;
    endcase
    acc_d = {sum[WIDTH], sum[WIDTH:1]};
    q_d   = {sum[0], q_q[WIDTH-1:1]};
    q1_d  = q_q[0];
`ifdef ALU_SEQ_DIV_EN
    // Divide runs on magnitudes; signs are reapplied on the way out
    a_mag   = op_a[WIDTH-1] ? -op_a : op_a;
    b_mag   = op_b[WIDTH-1] ? -op_b : op_b;
    shifted = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
    trial   = shifted - m_q;
    if (div_q) begin
      acc_d = trial[WIDTH] ? shifted : trial;
      q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
      q1_d  = 1'b0;
    end
`endif
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      acc_q     <= '0;
      m_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      cnt_q     <= '0;
      run_q     <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_q     <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else if (load) begin
      acc_q <= '0;
      q1_q  <= 1'b0;
      cnt_q <= '0;
      run_q <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
      div_q     <= is_div;
      neg_quo_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
      neg_rem_q <= op_a[WIDTH-1];
      if (is_div) begin
        q_q <= a_mag;
        m_q <= {1'b0, b_mag};
      end else begin
        q_q <= op_b;
        m_q <= {op_a[WIDTH-1], op_a};
      end
`else
      q_q <= op_b;
      m_q <= {op_a[WIDTH-1], op_a};
`endif
    end else if (run_q) begin
      acc_q <= acc_d;
      q_q   <= q_d;
      q1_q  <= q1_d;
      cnt_q <= cnt_q + CntW'(1);
      if (last) run_q <= 1'b0;
    end
  end

  always_comb begin
    res_lo = q_q;
    res_hi = acc_q[WIDTH-1:0];
`ifdef ALU_SEQ_DIV_EN
    if (div_q) begin
      res_lo = neg_quo_q ? -q_q : q_q;
      res_hi = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    end
`endif
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Multi-cycle ALU behind the opSelect/start/finished handshake; results held until next start.
// Signed divide is built only when ALU_SEQ_DIV_EN is defined, otherwise opcode 0x10 is illegal.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = WidthDef,
  parameter int unsigned MD_ITERS = MdItersDef
) (
  input  logic          Clock,
  input  logic          clear,
  alu_seq_unit_if.slave bus
);
  localparam int unsigned ShW = $clog2(WIDTH);

  state_e           state_q;
  logic [5:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] lo_q, hi_q;
  logic             fin_q, busy_q;

  logic             accept, md_load, md_last;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [WIDTH-1:0] sc_lo, sc_hi;
  logic [ShW-1:0]   shamt;

  assign accept = (state_q == StIdle) && bus.start;

  always_comb begin
    md_load = accept && (bus.opSelect == OpMul);
`ifdef ALU_SEQ_DIV_EN
    // Divide by zero takes the single-cycle path, so it never starts the iterator
    if (accept && (bus.opSelect == OpDiv) && (bus.B != '0)) md_load = 1'b1;
`endif
  end

  alu_muldiv_iter #(
    .WIDTH    (WIDTH),
    .MD_ITERS (MD_ITERS)
  ) u_muldiv (
    .Clock  (Clock),
    .clear  (clear),
    .load   (md_load),
`ifdef ALU_SEQ_DIV_EN
    .is_div (bus.opSelect == OpDiv),
`endif
    .op_a   (bus.A),
    .op_b   (bus.B),
    .last   (md_last),
    .res_lo (md_lo),
    .res_hi (md_hi)
  );

  always_comb begin
    shamt = b_q[ShW-1:0];
    sc_lo = '0;
    sc_hi = '0;
    case (op_q)
      OpAdd:  sc_lo = a_q + b_q;
      OpSub:  sc_lo = a_q - b_q;
      OpAnd:  sc_lo = a_q & b_q;
      OpOr:   sc_lo = a_q | b_q;
      OpNeg:  sc_lo = -a_q;
      OpNot:  sc_lo = ~a_q;
      OpShr:  sc_lo = a_q >> shamt;
      OpShra: sc_lo = $unsigned($signed(a_q) >>> shamt);
      OpShl:  sc_lo = a_q << shamt;
      // A shift by WIDTH yields zero, so amount 0 leaves A unchanged
      OpRor:  sc_lo = (a_q >> shamt) | (a_q << (WIDTH - 32'(shamt)));
      OpRol:  sc_lo = (a_q << shamt) | (a_q >> (WIDTH - 32'(shamt)));
      OpMul: begin
        sc_lo = md_lo;
        sc_hi = md_hi;
      end
`ifdef ALU_SEQ_DIV_EN
      OpDiv: begin
        if (b_q == '0) begin
          sc_lo = '1;
          sc_hi = a_q;
        end else begin
          sc_lo = md_lo;
          sc_hi = md_hi;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= StIdle;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            op_q    <= bus.opSelect;
            a_q     <= bus.A;
            b_q     <= bus.B;
            busy_q  <= 1'b1;
            fin_q   <= 1'b0;
            state_q <= md_load ? StIter : StDone;
          end
        end
        StIter: begin
          if (md_last) state_q <= StDone;
        end
        StDone: begin
          lo_q    <= sc_lo;
          hi_q    <= sc_hi;
          fin_q   <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.result_lo = lo_q;
  assign bus.result_hi = hi_q;
  assign bus.finished  = fin_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_seq_unit.sv
// Randomised bench for alu_seq_unit against a plain-arithmetic reference model.
// Divide expectations follow ALU_SEQ_DIV_EN as defined for the build.
module tb_alu_seq_unit;
  import alu_seq_pkg::*;

  logic Clock = 1'b0;
  logic clear;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 Clock = ~Clock;

  alu_seq_unit_if #(.WIDTH(32)) bus ();

  alu_seq_unit #(
    .WIDTH    (32),
    .MD_ITERS (32)
  ) dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [5:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0] r;
    longint      sa, sb, p, q, rm;
    int          n;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n  = int'(b[4:0]);
    r  = a;
    case (op)
      OpAdd:  return {32'h0, a + b};
      OpSub:  return {32'h0, a - b};
      OpAnd:  return {32'h0, a & b};
      OpOr:   return {32'h0, a | b};
      OpNeg:  return {32'h0, 32'h0 - a};
      OpNot:  return {32'h0, ~a};
      OpShr:  return {32'h0, a >> n};
      OpShl:  return {32'h0, a << n};
      OpShra: begin
        for (int i = 0; i < n; i++) r = {r[31], r[31:1]};
        return {32'h0, r};
      end
      OpRor: begin
        for (int i = 0; i < n; i++) r = {r[0], r[31:1]};
        return {32'h0, r};
      end
      OpRol: begin
        for (int i = 0; i < n; i++) r = {r[30:0], r[31]};
        return {32'h0, r};
      end
      OpMul: begin
        p = sa * sb;
        return p;
      end
`ifdef ALU_SEQ_DIV_EN
      OpDiv: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        q  = sa / sb;
        rm = sa % sb;
        return {rm[31:0], q[31:0]};
      end
`endif
      default: return 64'h0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [5:0] op, input logic [31:0] b);
    if (op == OpMul) return 33;
`ifdef ALU_SEQ_DIV_EN
    if (op == OpDiv && b != 32'h0) return 33;
`endif
    return 1;
  endfunction

  // el counts clock edges since the accept edge; bounded so a stuck DUT still terminates
  task automatic wait_done(inout int el);
    while (bus.finished !== 1'b1 && el < 80) begin
      @(negedge Clock);
      el++;
    end
  endtask

  // Called at a negedge; pulses start for one edge then scrambles the operand inputs.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag);
    logic [63:0] exp;
    int          exp_lat, el;
    exp     = ref_result(op, a, b);
    exp_lat = ref_latency(op, b);
    bus.opSelect = op;
    bus.A        = a;
    bus.B        = b;
    bus.start    = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.start    = 1'b0;
    bus.opSelect = 6'($urandom);
    bus.A        = $urandom;
    bus.B        = $urandom;
    check_eq({tag, ".busy_on"}, 64'(bus.busy), 64'd1);
    check_eq({tag, ".fin_clr"}, 64'(bus.finished), 64'd0);
    el = 0;
    wait_done(el);
    check_eq({tag, ".latency"}, 64'(el), 64'(exp_lat));
    check_eq({tag, ".busy_off"}, 64'(bus.busy), 64'd0);
    check_eq({tag, ".result"}, {bus.result_hi, bus.result_lo}, exp);
  endtask

  logic [5:0] legal_ops [14];
  logic [5:0] rop;
  logic [31:0] ra, rb;
  int el;

  initial begin
    legal_ops = '{OpAdd, OpSub, OpAnd, OpOr, OpMul, OpDiv, OpNeg, OpNot,
                  OpShr, OpShra, OpShl, OpRor, OpRol, 6'h3F};
    clear        = 1'b1;
    bus.start    = 1'b0;
    bus.opSelect = '0;
    bus.A        = '0;
    bus.B        = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check_eq("rst.lo", 64'(bus.result_lo), 64'd0);
    check_eq("rst.hi", 64'(bus.result_hi), 64'd0);
    check_eq("rst.finished", 64'(bus.finished), 64'd0);
    check_eq("rst.busy", 64'(bus.busy), 64'd0);
    clear = 1'b0;

    run_op(OpShr, 32'h8, 32'h2, "shr");
    check_eq("shr.const", {bus.result_hi, bus.result_lo}, 64'h2);
    run_op(OpMul, 32'hFFFF_FFFD, 32'd7, "mul");
    check_eq("mul.const", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFF_FFFF_FFEB);
`ifdef ALU_SEQ_DIV_EN
    run_op(OpDiv, 32'hFFFF_FFEF, 32'd5, "div");
    check_eq("div.const", {bus.result_hi, bus.result_lo}, 64'hFFFF_FFFE_FFFF_FFFD);
    run_op(OpDiv, 32'h1234, 32'h0, "div0");
    check_eq("div0.const", {bus.result_hi, bus.result_lo}, 64'h0000_1234_FFFF_FFFF);
`else
    run_op(OpDiv, 32'hFFFF_FFEF, 32'd5, "div_off");
    check_eq("div_off.const", {bus.result_hi, bus.result_lo}, 64'h0);
`endif
    run_op(OpRor, 32'h0000_00F1, 32'd4, "ror");
    run_op(6'h3F, 32'h1234, 32'h5678, "illegal");
    check_eq("illegal.const", {bus.result_hi, bus.result_lo}, 64'h0);

    // Re-pulse with new operands while busy: must be ignored
    bus.opSelect = OpMul;
    bus.A        = 32'd2;
    bus.B        = 32'd3;
    bus.start    = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.start = 1'b0;
    repeat (4) @(negedge Clock);
    bus.opSelect = OpAdd;
    bus.A        = 32'd100;
    bus.B        = 32'd100;
    bus.start    = 1'b1;
    @(negedge Clock);
    bus.start = 1'b0;
    el = 5;
    wait_done(el);
    check_eq("hs.latency", 64'(el), 64'd33);
    check_eq("hs.result", {bus.result_hi, bus.result_lo}, 64'd6);
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      check_eq("hs.sticky_fin", 64'(bus.finished), 64'd1);
      check_eq("hs.sticky_res", {bus.result_hi, bus.result_lo}, 64'd6);
    end

    // Abort a multiply with clear ten edges after acceptance
    bus.opSelect = OpMul;
    bus.A        = 32'h1234_5678;
    bus.B        = 32'h9ABC_DEF0;
    bus.start    = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    bus.start = 1'b0;
    repeat (9) @(negedge Clock);
    clear = 1'b1;
    @(negedge Clock);
    check_eq("clr.lo", 64'(bus.result_lo), 64'd0);
    check_eq("clr.hi", 64'(bus.result_hi), 64'd0);
    check_eq("clr.finished", 64'(bus.finished), 64'd0);
    check_eq("clr.busy", 64'(bus.busy), 64'd0);
    clear = 1'b0;
    run_op(OpAdd, 32'd5, 32'd7, "add_after_clr");
    check_eq("add.const", {bus.result_hi, bus.result_lo}, 64'd12);

    // clear and start together: start is dropped
    bus.opSelect = OpAdd;
    bus.A        = 32'd1;
    bus.B        = 32'd1;
    bus.start    = 1'b1;
    clear        = 1'b1;
    @(negedge Clock);
    clear     = 1'b0;
    bus.start = 1'b0;
    check_eq("clrstart.busy", 64'(bus.busy), 64'd0);
    repeat (2) @(negedge Clock);
    check_eq("clrstart.busy2", 64'(bus.busy), 64'd0);
    check_eq("clrstart.fin", 64'(bus.finished), 64'd0);
    check_eq("clrstart.lo", 64'(bus.result_lo), 64'd0);

    for (int i = 0; i < 150; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 13)];
      ra  = ($urandom_range(0, 3) == 0) ? 32'($signed($urandom_range(0, 40)) - 20) : $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op(rop, ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
